// File: rtl/m_bp_tracker_pkg.sv
// Shared widths and the in-flight branch record used by the tracker and its FIFO.
package m_bp_tracker_pkg;

  localparam int PHT_IW = 5;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic [PHT_IW-1:0] idx;
    logic              pred;
  } bp_rec_t;

endpackage

// File: rtl/m_bp_tracker_fifo.sv
// Generic circular-buffer FIFO with push/pop/clear; a push is accepted when full if a pop happens in the same cycle.
module m_bp_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int W     = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  input  logic         clr,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  // Pointers are AW bits wide, so DEPTH being a power of two gives the modulo wrap for free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/m_bp_tracker.sv
// In-flight conditional-branch tracker: resolves branches in order, drives gshare updates,
// raises a one-cycle redirect on mispredict and counts hits/misses.
module m_bp_tracker
  import m_bp_tracker_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              w_clk,
  input  logic              w_rst,
  input  logic              w_push,
  input  logic [PHT_IW-1:0] w_push_idx,
  input  logic              w_push_pred,
  input  logic              w_res,
  input  logic              w_res_tkn,
  input  logic [XLEN-1:0]   w_res_pc,
  input  logic              w_flush,
  output logic              w_full,
  output logic              w_empty,
  output logic              w_we,
  output logic [PHT_IW-1:0] w_wadr,
  output logic              w_tkn,
  output logic              w_miss,
  output logic [XLEN-1:0]   w_miss_pc,
  output logic [31:0]       w_hit_cnt,
  output logic [31:0]       w_miss_cnt
);

  localparam int RW = $bits(bp_rec_t);

  bp_rec_t       push_rec;
  bp_rec_t       head;
  logic [RW-1:0] head_bits;
  logic          res_v;
  logic          mispred;
  logic          clr;

  assign push_rec = '{idx: w_push_idx, pred: w_push_pred};
  assign head     = bp_rec_t'(head_bits);
  assign res_v    = w_res & ~w_empty;
  assign mispred  = res_v & (head.pred != w_res_tkn);
  // A mispredict or external flush empties the buffer; a same-cycle push is younger and dropped.
  assign clr      = w_flush | mispred;

  m_bp_fifo #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .W    (RW)
  ) u_fifo (
    .clk  (w_clk),
    .rst  (w_rst),
    .push (w_push & ~clr),
    .din  (push_rec),
    .pop  (res_v),
    .clr  (clr),
    .dout (head_bits),
    .full (w_full),
    .empty(w_empty)
  );

  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      w_we       <= 1'b0;
      w_wadr     <= '0;
      w_tkn      <= 1'b0;
      w_miss     <= 1'b0;
      w_miss_pc  <= '0;
      w_hit_cnt  <= '0;
      w_miss_cnt <= '0;
    end else begin
      w_we   <= res_v;
      w_tkn  <= res_v & w_res_tkn;
      w_miss <= mispred;
      if (res_v) w_wadr <= head.idx;
      if (mispred) begin
        w_miss_pc  <= w_res_pc;
        w_miss_cnt <= w_miss_cnt + 1'b1;
      end else if (res_v) begin
        w_hit_cnt <= w_hit_cnt + 1'b1;
      end
    end
  end

endmodule
